// File: rtl/mux_2x1_sel.sv
// 2-to-1 lane selector. Output is combinational (0 cycles) or registered (1 cycle), chosen by REG_OUT.
// No handshake: out is always valid and nothing ever stalls.
module mux_2x1_sel #(
  parameter int unsigned      WIDTH     = 1,
  parameter int unsigned      REG_OUT   = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s,
  input  logic [2*WIDTH-1:0] in,
  output logic [WIDTH-1:0]   out
);

  logic [WIDTH-1:0] lane0;
  logic [WIDTH-1:0] lane1;
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] out_q;

  assign lane0 = in[WIDTH-1:0];
  assign lane1 = in[2*WIDTH-1:WIDTH];

  // An unknown select yields X rather than favouring either lane.
  always_comb begin
    out_d = 'x;
    case (s)
      1'b0: out_d = lane0;
      1'b1: out_d = lane1;
      default: out_d = 'x;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= RESET_VAL;
    end else begin
      out_q <= out_d;
    end
  end

  // The register is always built so clk/rst stay connected; it is pruned when unused.
  assign out = (REG_OUT != 0) ? out_q : out_d;

endmodule

// File: tb/tb_mux_2x1_sel.sv
// Bench for mux_2x1_sel: combinational instances at WIDTH 1 and 8, registered instances at WIDTH 8.
// Expected values come from a shift-and-mask lane model and a tracked register value.
module tb_mux_2x1_sel;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        s1  = 1'b0;
  logic [1:0]  in1 = '0;
  logic        s8  = 1'b0;
  logic [15:0] in8 = '0;
  logic        o1;
  logic [7:0]  o8c;
  logic [7:0]  o8r;
  logic [7:0]  o8rv;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_r;
  logic [7:0] exp_rv;
  bit         model_valid = 1'b0;

  always #5 clk = ~clk;

  mux_2x1_sel #(.WIDTH(1), .REG_OUT(0)) u_w1_comb (
    .clk(clk), .rst(rst), .s(s1), .in(in1), .out(o1));
  mux_2x1_sel #(.WIDTH(8), .REG_OUT(0)) u_w8_comb (
    .clk(clk), .rst(rst), .s(s8), .in(in8), .out(o8c));
  mux_2x1_sel #(.WIDTH(8), .REG_OUT(1), .RESET_VAL(8'h00)) u_w8_reg (
    .clk(clk), .rst(rst), .s(s8), .in(in8), .out(o8r));
  mux_2x1_sel #(.WIDTH(8), .REG_OUT(1), .RESET_VAL(8'hA5)) u_w8_reg_rv (
    .clk(clk), .rst(rst), .s(s8), .in(in8), .out(o8rv));

  function automatic logic ref1(input logic sv, input logic [1:0] v);
    logic [1:0] sh;
    sh = v >> sv;
    return sh[0];
  endfunction

  function automatic logic [7:0] ref8(input logic sv, input logic [15:0] v);
    logic [15:0] sh;
    sh = v >> (sv ? 8 : 0);
    return sh[7:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one registered step: inputs change mid-cycle, out must hold until the edge.
  task automatic reg_step(input logic r, input logic sv, input logic [15:0] iv, input string tag);
    @(negedge clk);
    rst = r;
    s8  = sv;
    in8 = iv;
    #1;
    if (model_valid) begin
      check({tag, "_hold"}, {56'd0, o8r}, {56'd0, exp_r});
      check({tag, "_hold_rv"}, {56'd0, o8rv}, {56'd0, exp_rv});
    end
    @(posedge clk);
    #1;
    exp_r  = r ? 8'h00 : ref8(sv, iv);
    exp_rv = r ? 8'hA5 : ref8(sv, iv);
    model_valid = 1'b1;
    check(tag, {56'd0, o8r}, {56'd0, exp_r});
    check({tag, "_rv"}, {56'd0, o8rv}, {56'd0, exp_rv});
  endtask

  initial begin
    logic [7:0] truth;
    logic [2:0] idx;
    truth = 8'b1100_1010;

    // Exhaustive WIDTH=1 truth table, one step per ns.
    for (int i = 0; i < 8; i++) begin
      idx = 3'(i);
      s1  = idx[2];
      in1 = idx[1:0];
      #1;
      check($sformatf("tt%0d", i), {63'd0, o1}, {63'd0, truth[i]});
      check($sformatf("tt_model%0d", i), {63'd0, o1}, {63'd0, ref1(s1, in1)});
    end

    // Free-running count on in, select toggling every 4 ns.
    for (int t = 0; t < 16; t++) begin
      s1  = ((t / 4) % 2) != 0;
      in1 = 2'(t);
      #1;
      check($sformatf("free_t%0d", t), {63'd0, o1}, {63'd0, ref1(s1, in1)});
    end

    // Unknown select, then recovery with no clock involvement.
    s1  = 1'bx;
    in1 = 2'b01;
    #1;
    checks++;
    assert ((o1 === 1'bx) || (o1 === 1'b1)) else begin
      errors++;
      $error("FAIL sel_x observed=%b expected=x", o1);
    end
    s1 = 1'b0;
    #1;
    check("sel_x_recover", {63'd0, o1}, 64'd1);

    // Wide combinational lanes.
    in8 = 16'hA55A;
    s8  = 1'b0;
    #1;
    check("wide_s0", {56'd0, o8c}, 64'h5A);
    s8 = 1'b1;
    #1;
    check("wide_s1", {56'd0, o8c}, 64'hA5);
    for (int i = 0; i < 20; i++) begin
      s8  = 1'($urandom_range(0, 1));
      in8 = 16'($urandom);
      #1;
      check($sformatf("wide_rand%0d", i), {56'd0, o8c}, {56'd0, ref8(s8, in8)});
    end

    // Registered path: reset state, latency, mid-stream reset, release.
    reg_step(1'b1, 1'b0, 16'h3CC3, "reg_reset");
    reg_step(1'b0, 1'b0, 16'h3CC3, "reg_lane0");
    reg_step(1'b0, 1'b1, 16'h3CC3, "reg_latency");
    reg_step(1'b1, 1'b1, 16'h3CC3, "reg_rst_mid");
    reg_step(1'b1, 1'b0, 16'h1234, "reg_rst_hold");
    reg_step(1'b0, 1'b1, 16'h3CC3, "reg_release");
    for (int i = 0; i < 24; i++) begin
      reg_step(($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), 16'($urandom),
               $sformatf("reg_rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
